// File: rtl/diff_encoder.sv
// Temporal difference encoder: streams a raw key frame, then per-element differences
// against the matching element of the previous frame, with a one-deep registered output.
module diff_encoder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_key,
    output logic             out_last
);

    localparam int IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

    typedef enum logic [0:0] {
        StKey,
        StDelta
    } state_t;

    state_t            r_state;
    logic [IdxW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_ref [DEPTH];
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_key;
    logic              r_out_last;

    logic              w_accept;
    logic              w_at_last;
    logic [WIDTH-1:0]  w_ref;
    logic [WIDTH-1:0]  w_result;

    // The output slot may be refilled in the same cycle it is drained.
    assign in_ready  = !flush && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_at_last = (r_idx == LastIdx);
    assign w_ref     = r_ref[r_idx];
    assign w_result  = (r_state == StKey) ? in_data : (in_data - w_ref);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StKey;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_key   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (flush) begin
                r_state <= StKey;
                r_idx   <= '0;
            end else if (w_accept) begin
                r_idx <= w_at_last ? '0 : r_idx + IdxW'(1);
                if (w_at_last) begin
                    r_state <= StDelta;
                end
            end

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_out_key   <= (r_state == StKey);
                r_out_last  <= w_at_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Reference store needs no reset: a key frame fills every entry before a delta reads it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ref[r_idx] <= in_data;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_key   = r_out_key;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_diff_encoder.sv
// Self-checking bench for diff_encoder (WIDTH=8, DEPTH=4): directed frames plus randomized
// traffic against a frame-level reference model and a decoder-side reconstruction.
module tb_diff_encoder;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_key;
    logic         out_last;

    diff_encoder #(
        .WIDTH(W),
        .DEPTH(D)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_key  (out_key),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame mode, position in frame, previous frame, pending output.
    bit m_key;
    int m_pos;
    int m_ref [D];
    bit e_valid;
    int e_data;
    bit e_key;
    bit e_last;

    int got_q [$];
    int sent_q [$];
    bit rc_en = 1'b0;
    int rc_pos;
    int rc_ref [D];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0;
        m_key   = 1'b1;
        m_pos   = 0;
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, then advance the model.
    task automatic drive(input bit v, input int d, input bit fl, input bit rdy);
        bit exp_ready;
        bit acc;
        bit take;
        in_valid  = v;
        in_data   = d[7:0];
        flush     = fl;
        out_ready = rdy;
        @(negedge clk);
        exp_ready = !fl && (!e_valid || rdy);
        chk("in_ready", int'(in_ready), int'(exp_ready));
        chk("out_valid", int'(out_valid), int'(e_valid));
        if (e_valid) begin
            chk("out_data", int'(out_data), e_data);
            chk("out_key", int'(out_key), int'(e_key));
            chk("out_last", int'(out_last), int'(e_last));
        end
        acc  = v && exp_ready;
        take = e_valid && rdy;
        if (take) begin
            got_q.push_back(int'(out_data));
            if (rc_en) begin
                if (out_key) rc_ref[rc_pos] = int'(out_data);
                else rc_ref[rc_pos] = (rc_ref[rc_pos] + int'(out_data)) % 256;
                chk("recon_avail", int'(sent_q.size() > 0), 1);
                if (sent_q.size() > 0) chk("recon", rc_ref[rc_pos], sent_q.pop_front());
                rc_pos = (rc_pos + 1) % D;
            end
        end
        if (acc && rc_en) sent_q.push_back(d % 256);
        @(posedge clk);
        if (fl) begin
            m_key = 1'b1;
            m_pos = 0;
        end
        if (acc) begin
            e_valid = 1'b1;
            e_data  = m_key ? (d % 256) : ((d % 256) - m_ref[m_pos] + 256) % 256;
            e_key   = m_key;
            e_last  = (m_pos == D - 1);
            m_ref[m_pos] = d % 256;
            if (m_pos == D - 1) begin
                m_pos = 0;
                m_key = 1'b0;
            end else begin
                m_pos++;
            end
        end else if (take) begin
            e_valid = 1'b0;
        end
        #1;
    endtask

    // Reset asserted and released between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_key", int'(out_key), 0);
        chk("rst_out_last", int'(out_last), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int f31 [8] = '{10, 20, 30, 40, 12, 19, 30, 45};
    int x31 [8] = '{10, 20, 30, 40, 2, 255, 0, 5};
    int f32 [16] = '{250, 1, 2, 3, 4, 1, 2, 3, 5, 1, 2, 3, 0, 1, 2, 3};
    int x33 [4] = '{11, 22, 33, 44};

    initial begin
        model_reset();
        do_reset();

        // Two frames at full throughput.
        got_q.delete();
        foreach (f31[i]) drive(1'b1, f31[i], 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("f31_count", got_q.size(), 8);
        foreach (x31[i]) if (i < got_q.size()) chk("f31_data", got_q[i], x31[i]);

        // Modular wrap of differences.
        do_reset();
        got_q.delete();
        foreach (f32[i]) drive(1'b1, f32[i], 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("f32_count", got_q.size(), 16);
        if (got_q.size() == 16) begin
            chk("wrap_up", got_q[4], 10);
            chk("wrap_small", got_q[8], 1);
            chk("wrap_down", got_q[12], 251);
        end

        // Backpressure with in_valid held high.
        do_reset();
        got_q.delete();
        drive(1'b1, 11, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 22, 1'b0, 1'b0);
        drive(1'b1, 22, 1'b0, 1'b1);
        drive(1'b1, 33, 1'b0, 1'b1);
        drive(1'b1, 44, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("bp_count", got_q.size(), 4);
        foreach (x33[i]) if (i < got_q.size()) chk("bp_data", got_q[i], x33[i]);

        // Flush in KEY at idx 0 is a no-op; flush mid DELTA frame keeps the pending output.
        do_reset();
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < D; i++) drive(1'b1, 100 + i, 1'b0, 1'b1);
        drive(1'b1, 50, 1'b0, 1'b1);
        drive(1'b1, 60, 1'b0, 1'b0);
        drive(1'b1, 70, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1);
        drive(1'b1, 80, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);

        // Reset mid-frame with an output pending.
        for (int i = 0; i < D; i++) drive(1'b1, 7 * i, 1'b0, 1'b1);
        drive(1'b1, 90, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < D + 2; i++) drive(1'b1, 3 + i, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);

        // Random stalls, checked through decoder-side reconstruction.
        do_reset();
        rc_en  = 1'b1;
        rc_pos = 0;
        sent_q.delete();
        repeat (400) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 255), 1'b0,
                  $urandom_range(0, 3) != 0);
        end
        repeat (4) drive(1'b0, 0, 1'b0, 1'b1);
        chk("recon_left", sent_q.size(), 0);
        rc_en = 1'b0;

        // Random traffic with occasional flushes.
        repeat (300) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (2) drive(1'b0, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
